video_cap_pack: RTL and testbench
=================================

// Module: video_cap_pack
// PURPOSE
//  Single-clock, parametrised successor to the dual-clock capture front end.
//  - Packs DVD_CHN serial bytes per pixel from a DVD/DVSYN/DHSYN source into one word.
//  - Routes lines 0..IH-1 to a backpressured pixel stream; lines IH..IH+CMD_LINES-1 go to a command stream.
//  - Tracks frames and raises img_en after SKIP_FRAMES complete frames.
// PARAMETERS
//  DW_DVD      8    bits per input byte
//  DVD_CHN     3    bytes per pixel, legal 1..8
//  IW          640  pixels per line
//  IH          512  image lines per frame
//  CMD_LINES   1    trailing command lines per frame, legal 0..15
//  FIFO_AW     4    pixel FIFO address width; depth = 2**FIFO_AW
//  SKIP_FRAMES 4    frames to discard before img_en, legal 1..255
//  CNT_W       16   frame counter width
// PORTS
//  cap_clk    in   1               capture clock; all logic on posedge
//  reset_l    in   1               asynchronous reset, active-low
//  DVD        in   DW_DVD          input byte, sampled when DHSYN=1
//  DVSYN      in   1               frame valid, active-high
//  DHSYN      in   1               line valid, active-high
//  pix_dat    out  DW_DVD*DVD_CHN  packed pixel; byte k of line -> lane k (lane 0 = LSBs)
//  pix_valid  out  1               pixel word available (FIFO not empty)
//  pix_ready  in   1               sink accepts; transfer = pix_valid & pix_ready
//  pix_sof    out  1               sideband: first pixel of frame
//  pix_eol    out  1               sideband: last pixel of line
//  cmd_dat    out  DW_DVD*DVD_CHN  command-line word, no backpressure
//  cmd_valid  out  1               one-cycle strobe per command word
//  img_en     out  1               image output enabled (sticky)
//  frame_cnt  out  CNT_W           completed frames, wraps
//  ovf_err    out  1               sticky pixel FIFO overflow, cleared at frame start
//  line_err   out  1               line-length error pulse (VCAP_LINE_CHECK_EN only)
//  err_cnt    out  8               saturating line-error count (VCAP_LINE_CHECK_EN only)
// BEHAVIOUR
//  - Reset: every output 0; FIFO empty; byte, pixel and line counters 0; sof_pending = 1.
//  - DVSYN edges:
//    - Frame start = DVSYN 0->1. Clears line counter and ovf_err; sets sof_pending.
//    - Frame end = DVSYN 1->0. frame_cnt += 1 (wraps).
//    - img_en sets on the frame end that makes frame_cnt reach SKIP_FRAMES; sticky until reset.
//  - Packing:
//    - Byte counter advances on each cycle with DHSYN=1.
//    - Byte DVD_CHN-1 completes the pixel. Counter returns to 0; word is registered (stage P).
//    - DHSYN 1->0 with a partial pixel: partial bytes are discarded. The line ends on the last complete pixel.
//  - Line counter increments on DHSYN 1->0, only while DVSYN=1.
//  - Routing by current line index L:
//    - L < IH: word written to FIFO one cycle after stage P.
//    - IH <= L < IH+CMD_LINES: word drives cmd_dat with cmd_valid=1 for one cycle, cycle after stage P.
//    - Otherwise the word is dropped.
//  - Latency: last byte sampled at cycle n -> FIFO write n+1 -> pix_valid n+2 when FIFO was empty.
//  - Pixel FIFO:
//    - Width DW_DVD*DVD_CHN+2, holding {eol, sof, data}. Show-ahead: pix_dat/pix_sof/pix_eol valid whenever pix_valid=1.
//    - sof = sof_pending at write; sof_pending clears on that write.
//    - eol is set on the word whose pixel index = IW-1, or on the last complete pixel before DHSYN falls, whichever comes first.
//    - Pixels beyond IW-1 in a line are dropped.
//    - Full on write: write dropped, ovf_err = 1. Simultaneous read+write when full: both proceed, no overflow.
//  - DVSYN falling mid-line: line abandoned, partial pixel discarded. No eol is forced.
//  - Async reset mid-frame: immediate clear. Capture resumes at the next frame start; earlier DHSYN activity is ignored.
// CONFIGURATION
//  VCAP_LINE_CHECK_EN defined:
//    - At DHSYN 1->0 on lines L < IH, complete-pixel count != IW produces line_err = 1 for one cycle.
//    - err_cnt increments on each such error and saturates at 255.
//  Not defined: line_err and err_cnt are tied to 0; no checker logic is built.
// TESTING
//  1. DVD_CHN=3, line bytes 01..06 -> pix_dat 0x030201 then 0x060504; sof on the first word; pix_valid 2 cycles after the 3rd byte.
//  2. Hold pix_ready=0 with FIFO_AW=4 and send 20 pixels -> 16 stored, ovf_err=1. The next DVSYN rise clears ovf_err.
//  3. IH=2, CMD_LINES=1: line 2 of 4 pixels -> 4 cmd_valid strobes; FIFO untouched; line 3 dropped.
//  4. 7-byte line with DVD_CHN=3 -> 2 pixels; eol on the 2nd. With VCAP_LINE_CHECK_EN and IW=3 -> line_err pulse, err_cnt=1.
//  5. SKIP_FRAMES=2 -> img_en rises on the 2nd DVSYN fall. Reset_l pulse mid-line 3 -> all outputs 0; the next frame packs cleanly.

Source files
------------

// File: rtl/video_cap_pack.sv
// Single-clock video capture: packs DVD_CHN bytes per pixel, routes image lines to a
// show-ahead pixel FIFO and trailing lines to a command strobe. Optional: VCAP_LINE_CHECK_EN.
module video_cap_pack #(
    parameter int unsigned DW_DVD      = 8,
    parameter int unsigned DVD_CHN     = 3,
    parameter int unsigned IW          = 640,
    parameter int unsigned IH          = 512,
    parameter int unsigned CMD_LINES   = 1,
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned SKIP_FRAMES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                        cap_clk,
    input  logic                        reset_l,
    input  logic [DW_DVD-1:0]           DVD,
    input  logic                        DVSYN,
    input  logic                        DHSYN,
    output logic [DW_DVD*DVD_CHN-1:0]   pix_dat,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic                        pix_sof,
    output logic                        pix_eol,
    output logic [DW_DVD*DVD_CHN-1:0]   cmd_dat,
    output logic                        cmd_valid,
    output logic                        img_en,
    output logic [CNT_W-1:0]            frame_cnt,
    output logic                        ovf_err,
    output logic                        line_err,
    output logic [7:0]                  err_cnt
);
    localparam int unsigned PW    = DW_DVD * DVD_CHN;
    localparam int unsigned FW    = PW + 2;
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned BCW   = (DVD_CHN > 1) ? $clog2(DVD_CHN) : 1;
    localparam int unsigned PCW   = $clog2(IW + 2);
    localparam int unsigned LW    = $clog2(IH + CMD_LINES + 1);

    logic               dvsyn_q, dhsyn_q, in_frame_q, in_frame_d;
    logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [PCW-1:0]     pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]      line_q, line_d, line_now;
    logic               p_valid_q, p_valid_d, p_img_q, p_img_d, p_cmd_q, p_cmd_d;
    logic [PCW-1:0]     p_idx_q, p_idx_d;
    logic [PW-1:0]      p_dat_q, p_dat_d;
    logic               sof_pend_q, sof_pend_d, last_wr_q, last_wr_d;
    logic [FIFO_AW-1:0] last_ptr_q, last_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [FW-1:0]      mem_q [DEPTH];
    logic [FW-1:0]      rd_word;
    logic [PW-1:0]      cmd_dat_q, cmd_dat_d;
    logic               cmd_valid_q, cmd_valid_d, img_en_q, img_en_d, ovf_q, ovf_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               frame_start, frame_end, dh_fall, take, pix_done;
    logic               full, do_rd, wr_req, wr_eol, do_wr, patch;

    // Sync edge detection, byte packing, line routing and FIFO control
    always_comb begin
        in_frame_d  = in_frame_q;
        byte_cnt_d  = byte_cnt_q;
        acc_d       = acc_q;
        pix_cnt_d   = pix_cnt_q;
        line_d      = line_q;
        sof_pend_d  = sof_pend_q;
        last_wr_d   = last_wr_q;
        last_ptr_d  = last_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        cmd_dat_d   = cmd_dat_q;
        ovf_d       = ovf_q;
        frame_cnt_d = frame_cnt_q;
        img_en_d    = img_en_q;

        frame_start = DVSYN & ~dvsyn_q;
        frame_end   = ~DVSYN & dvsyn_q & in_frame_q;
        dh_fall     = dhsyn_q & ~DHSYN;
        in_frame_d  = frame_start | (in_frame_q & DVSYN);
        take        = DHSYN & in_frame_d;
        line_now    = frame_start ? '0 : line_q;

        if (take) acc_d[32'(byte_cnt_q) * DW_DVD +: DW_DVD] = DVD;
        pix_done   = take & (byte_cnt_q == BCW'(DVD_CHN - 1));
        byte_cnt_d = (!take || pix_done) ? '0 : byte_cnt_q + BCW'(1);

        if (!DHSYN) pix_cnt_d = '0;
        else if (pix_done && pix_cnt_q != PCW'(IW + 1)) pix_cnt_d = pix_cnt_q + PCW'(1);

        p_valid_d = pix_done;
        p_dat_d   = acc_d;
        p_idx_d   = pix_cnt_q;
        p_img_d   = line_now < LW'(IH);
        p_cmd_d   = !p_img_d && (line_now < LW'(IH + CMD_LINES));

        if (frame_start) line_d = '0;
        else if (dh_fall && DVSYN && in_frame_q && line_q != LW'(IH + CMD_LINES))
            line_d = line_q + LW'(1);

        full   = (cnt_q == CW'(DEPTH));
        do_rd  = (cnt_q != '0) & pix_ready;
        wr_req = p_valid_q & p_img_q & (p_idx_q < PCW'(IW));
        wr_eol = (p_idx_q == PCW'(IW - 1)) | dh_fall;
        do_wr  = wr_req & (~full | do_rd);
        // A trailing partial pixel hides the line end; mark eol on the word already queued
        patch  = dh_fall & ~p_valid_q & last_wr_q & (cnt_q != '0);

        if (do_wr) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (frame_start) ovf_d = 1'b0;
        if (wr_req && !do_wr) ovf_d = 1'b1;

        if (frame_start) sof_pend_d = 1'b1;
        else if (do_wr) sof_pend_d = 1'b0;

        if (frame_start || frame_end || dh_fall) last_wr_d = 1'b0;
        if (do_wr) begin
            last_wr_d  = ~wr_eol;
            last_ptr_d = wr_ptr_q;
        end

        cmd_valid_d = p_valid_q & p_cmd_q;
        if (cmd_valid_d) cmd_dat_d = p_dat_q;

        if (frame_end) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            if (frame_cnt_d == CNT_W'(SKIP_FRAMES)) img_en_d = 1'b1;
        end
    end

    // dvsyn_q resets high so a frame already in progress at reset release is not captured
    always_ff @(posedge cap_clk or negedge reset_l) begin
        if (!reset_l) begin
            dvsyn_q     <= 1'b1;
            dhsyn_q     <= 1'b0;
            in_frame_q  <= 1'b0;
            byte_cnt_q  <= '0;
            acc_q       <= '0;
            pix_cnt_q   <= '0;
            line_q      <= '0;
            p_valid_q   <= 1'b0;
            p_img_q     <= 1'b0;
            p_cmd_q     <= 1'b0;
            p_idx_q     <= '0;
            p_dat_q     <= '0;
            sof_pend_q  <= 1'b1;
            last_wr_q   <= 1'b0;
            last_ptr_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            cmd_dat_q   <= '0;
            cmd_valid_q <= 1'b0;
            img_en_q    <= 1'b0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            dvsyn_q     <= DVSYN;
            dhsyn_q     <= DHSYN;
            in_frame_q  <= in_frame_d;
            byte_cnt_q  <= byte_cnt_d;
            acc_q       <= acc_d;
            pix_cnt_q   <= pix_cnt_d;
            line_q      <= line_d;
            p_valid_q   <= p_valid_d;
            p_img_q     <= p_img_d;
            p_cmd_q     <= p_cmd_d;
            p_idx_q     <= p_idx_d;
            p_dat_q     <= p_dat_d;
            sof_pend_q  <= sof_pend_d;
            last_wr_q   <= last_wr_d;
            last_ptr_q  <= last_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            cmd_dat_q   <= cmd_dat_d;
            cmd_valid_q <= cmd_valid_d;
            img_en_q    <= img_en_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // FIFO storage {eol, sof, data}
    always_ff @(posedge cap_clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= {wr_eol, sof_pend_q, p_dat_q};
        else if (patch) mem_q[last_ptr_q][FW-1] <= 1'b1;
    end

    assign rd_word   = mem_q[rd_ptr_q];
    assign pix_valid = (cnt_q != '0);
    assign pix_dat   = pix_valid ? rd_word[PW-1:0] : '0;
    assign pix_sof   = pix_valid & rd_word[PW];
    assign pix_eol   = pix_valid & rd_word[PW+1];
    assign cmd_dat   = cmd_dat_q;
    assign cmd_valid = cmd_valid_q;
    assign img_en    = img_en_q;
    assign frame_cnt = frame_cnt_q;
    assign ovf_err   = ovf_q;

`ifdef VCAP_LINE_CHECK_EN
    logic       line_err_q, line_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Complete-pixel count of each image line must equal IW
    always_comb begin
        line_err_d = dh_fall & in_frame_q & (line_q < LW'(IH)) & (pix_cnt_q != PCW'(IW));
        err_cnt_d  = err_cnt_q;
        if (line_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge cap_clk or negedge reset_l) begin
        if (!reset_l) begin
            line_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            line_err_q <= line_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign line_err = line_err_q;
    assign err_cnt  = err_cnt_q;
`else
    assign line_err = 1'b0;
    assign err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_video_cap_pack.sv
// Scoreboard bench for video_cap_pack: stimulus pushes expected words, monitors pop on output.
module tb_video_cap_pack;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 24;

    logic          cap_clk, reset_l;
    logic [DW-1:0] DVD;
    logic          DVSYN, DHSYN, pix_ready;
    logic [PW-1:0] pix_dat, cmd_dat;
    logic          pix_valid, pix_sof, pix_eol, cmd_valid, img_en, ovf_err, line_err;
    logic [15:0]   frame_cnt;
    logic [7:0]    err_cnt;

    int total = 0;
    int bad   = 0;
    logic [PW+1:0] pix_q [$];
    logic [PW-1:0] cmd_q [$];

    video_cap_pack #(
        .DW_DVD(8), .DVD_CHN(3), .IW(10), .IH(2), .CMD_LINES(1),
        .FIFO_AW(4), .SKIP_FRAMES(2), .CNT_W(16)
    ) dut (
        .cap_clk(cap_clk), .reset_l(reset_l), .DVD(DVD), .DVSYN(DVSYN), .DHSYN(DHSYN),
        .pix_dat(pix_dat), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .cmd_dat(cmd_dat), .cmd_valid(cmd_valid),
        .img_en(img_en), .frame_cnt(frame_cnt), .ovf_err(ovf_err),
        .line_err(line_err), .err_cnt(err_cnt)
    );

    initial cap_clk = 1'b0;
    always #5 cap_clk = ~cap_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] d, input logic v, input logic h);
        DVD = d; DVSYN = v; DHSYN = h;
        @(posedge cap_clk); #1;
    endtask

    task automatic line_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) cyc(base + 8'(i), 1'b1, 1'b1);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
    endtask

    task automatic push_pix(input logic eol, input logic sof, input logic [7:0] b);
        pix_q.push_back({eol, sof, b + 8'd2, b + 8'd1, b});
    endtask

    task automatic drain();
        pix_ready = 1'b1;
        for (int i = 0; i < 60 && pix_q.size() != 0; i++) begin
            @(posedge cap_clk); #1;
        end
        chk("drain_empty", 32'(pix_q.size()), 32'd0);
    endtask

    // Pixel and command monitors
    always @(negedge cap_clk) begin
        if (reset_l && pix_valid && pix_ready) begin
            if (pix_q.size() == 0) begin
                total++; bad++;
                $display("FAIL pix_unexpected: got %0h want none", {pix_eol, pix_sof, pix_dat});
            end else begin
                chk("pix_word", 32'({pix_eol, pix_sof, pix_dat}), 32'(pix_q.pop_front()));
            end
        end
        if (reset_l && cmd_valid) begin
            if (cmd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL cmd_unexpected: got %0h want none", cmd_dat);
            end else begin
                chk("cmd_word", 32'(cmd_dat), 32'(cmd_q.pop_front()));
            end
        end
    end

    initial begin
        reset_l = 1'b0; DVD = '0; DVSYN = 1'b0; DHSYN = 1'b0; pix_ready = 1'b0;
        repeat (3) @(posedge cap_clk);
        #1;
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_dat",   32'(pix_dat),   32'd0);
        chk("rst_pix_sof",   32'(pix_sof),   32'd0);
        chk("rst_pix_eol",   32'(pix_eol),   32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_dat",   32'(cmd_dat),   32'd0);
        chk("rst_img_en",    32'(img_en),    32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_ovf_err",   32'(ovf_err),   32'd0);
        chk("rst_line_err",  32'(line_err),  32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        reset_l = 1'b1;
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);

        // Frame 1: packing, latency, IW overflow, command line, dropped line
        pix_ready = 1'b1;
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        pix_q.push_back({1'b0, 1'b1, 24'h030201});
        pix_q.push_back({1'b1, 1'b0, 24'h060504});
        cyc(8'h01, 1'b1, 1'b1);
        cyc(8'h02, 1'b1, 1'b1);
        cyc(8'h03, 1'b1, 1'b1);
        chk("lat_not_yet", 32'(pix_valid), 32'd0);
        cyc(8'h04, 1'b1, 1'b1);
        chk("lat_valid", 32'(pix_valid), 32'd1);
        chk("lat_sof",   32'(pix_sof),   32'd1);
        chk("lat_dat",   32'(pix_dat),   32'h030201);
        cyc(8'h05, 1'b1, 1'b1);
        cyc(8'h06, 1'b1, 1'b1);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        for (int p = 0; p < 10; p++) push_pix(p == 9, 1'b0, 8'h10 + 8'(3 * p));
        line_bytes(8'h10, 36);
        cmd_q.push_back(24'h424140);
        cmd_q.push_back(24'h454443);
        cmd_q.push_back(24'h484746);
        cmd_q.push_back(24'h4B4A49);
        line_bytes(8'h40, 12);
        chk("cmd_all_seen", 32'(cmd_q.size()), 32'd0);
        line_bytes(8'h70, 6);
        chk("drop_no_pix", 32'(pix_valid), 32'd0);
        cyc(8'h00, 1'b0, 1'b0);
        chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("f1_img_en",    32'(img_en),    32'd0);
`ifdef VCAP_LINE_CHECK_EN
        chk("f1_err_cnt", 32'(err_cnt), 32'd2);
`endif
        cyc(8'h00, 1'b0, 1'b0);

        // Frame 2: 20 pixels with sink stalled, 16 stored, overflow
        pix_ready = 1'b0;
        cyc(8'h00, 1'b1, 1'b0);
        for (int p = 0; p < 10; p++) push_pix(p == 9, p == 0, 8'h60 + 8'(3 * p));
        for (int p = 0; p < 6; p++)  push_pix(1'b0, 1'b0, 8'h80 + 8'(3 * p));
        line_bytes(8'h60, 30);
        chk("ovf_before_full", 32'(ovf_err), 32'd0);
        line_bytes(8'h80, 30);
        chk("ovf_set",    32'(ovf_err),   32'd1);
        chk("full_valid", 32'(pix_valid), 32'd1);
        chk("img_en_pre", 32'(img_en),    32'd0);
        cyc(8'h00, 1'b0, 1'b0);
        chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("img_en_rise",  32'(img_en),    32'd1);
        drain();
        chk("ovf_sticky", 32'(ovf_err), 32'd1);

        // Frame 3: 7-byte line, eol lands on the second pixel
        pix_ready = 1'b0;
        cyc(8'h00, 1'b1, 1'b0);
        chk("ovf_frame_clr", 32'(ovf_err), 32'd0);
        push_pix(1'b0, 1'b1, 8'hA0);
        push_pix(1'b1, 1'b0, 8'hA3);
        for (int i = 0; i < 7; i++) cyc(8'hA0 + 8'(i), 1'b1, 1'b1);
        cyc(8'h00, 1'b1, 1'b0);
`ifdef VCAP_LINE_CHECK_EN
        chk("line_err_pulse", 32'(line_err), 32'd1);
        chk("f3_err_cnt",     32'(err_cnt),  32'd3);
`endif
        cyc(8'h00, 1'b1, 1'b0);
`ifdef VCAP_LINE_CHECK_EN
        chk("line_err_drop", 32'(line_err), 32'd0);
`endif
        drain();

        // Reset mid-line, then activity inside the interrupted frame is ignored
        cyc(8'hB0, 1'b1, 1'b1);
        cyc(8'hB1, 1'b1, 1'b1);
        reset_l = 1'b0;
        #2;
        chk("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("mid_rst_pix_dat",   32'(pix_dat),   32'd0);
        chk("mid_rst_img_en",    32'(img_en),    32'd0);
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst_err_cnt",   32'(err_cnt),   32'd0);
        @(posedge cap_clk); #1;
        reset_l = 1'b1;
        line_bytes(8'hB2, 9);
        chk("ignored_line", 32'(pix_valid), 32'd0);
        cyc(8'h00, 1'b0, 1'b0);
        chk("ignored_frame_end", 32'(frame_cnt), 32'd0);

        // Frame 4: clean capture after reset
        pix_ready = 1'b1;
        cyc(8'h00, 1'b1, 1'b0);
        push_pix(1'b0, 1'b1, 8'hC0);
        push_pix(1'b1, 1'b0, 8'hC3);
        line_bytes(8'hC0, 6);
        drain();
        cyc(8'h00, 1'b0, 1'b0);
        chk("f4_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("f4_img_en",    32'(img_en),    32'd0);
`ifdef VCAP_LINE_CHECK_EN
        chk("f4_err_cnt", 32'(err_cnt), 32'd1);
`endif
        cyc(8'h00, 1'b0, 1'b0);
        chk("end_pix_q", 32'(pix_q.size()), 32'd0);
        chk("end_cmd_q", 32'(cmd_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
